// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared stage record and parameter check for pipelined arithmetic blocks
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV
package adder_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_t;

  function automatic bit stages_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (width % stages == 0);
  endfunction

endpackage

// Expands to a generate-if at the use site, so a bad WIDTH/STAGES pair fails elaboration.
`define ADDER_PARAM_CHECK(W, S) \
  if (!adder_pkg::stages_ok(W, S)) begin : g_param_err \
    $error("pipelined adder: WIDTH must be a positive multiple of STAGES"); \
  end
`endif

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational CHUNK-bit x + y + ci -> s, co
module add_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - valid/ready pipelined ripple-carry adder, one carry chunk per stage
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  `ADDER_PARAM_CHECK(WIDTH, STAGES)

  // x holds finished sum bits below the stage boundary and pending a bits above it
  stage_t           stg_q [STAGES];
  stage_t           stg_d [STAGES];
  logic [WIDTH-1:0] x_q   [STAGES];
  logic [WIDTH-1:0] x_d   [STAGES];
  logic [WIDTH-1:0] y_q   [STAGES];
  logic [WIDTH-1:0] y_d   [STAGES];
  logic [1:0]       msb_q [STAGES];
  logic [1:0]       msb_d [STAGES];

  logic [STAGES-1:0]            up_valid_w;
  logic [STAGES-1:0]            up_carry_w;
  logic [STAGES-1:0][WIDTH-1:0] up_x_w;
  logic [STAGES-1:0][WIDTH-1:0] up_y_w;
  logic [STAGES-1:0][1:0]       up_msb_w;
  logic [STAGES-1:0][CHUNK-1:0] s_w;
  logic [STAGES-1:0]            co_w;
  logic [STAGES-1:0]            rdy_w;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign up_valid_w[k] = in_valid;
      assign up_carry_w[k] = cin;
      assign up_x_w[k]     = a;
      assign up_y_w[k]     = b;
      assign up_msb_w[k]   = {a[WIDTH-1], b[WIDTH-1]};
    end else begin : g_next
      assign up_valid_w[k] = stg_q[k-1].valid;
      assign up_carry_w[k] = stg_q[k-1].carry;
      assign up_x_w[k]     = x_q[k-1];
      assign up_y_w[k]     = y_q[k-1];
      assign up_msb_w[k]   = msb_q[k-1];
    end

    add_slice #(.CHUNK(CHUNK)) u_slice (
      .x  (up_x_w[k][k*CHUNK +: CHUNK]),
      .y  (up_y_w[k][k*CHUNK +: CHUNK]),
      .ci (up_carry_w[k]),
      .s  (s_w[k]),
      .co (co_w[k])
    );
  end

  // A stage can take new data if it is empty or everything downstream of it can move.
  always_comb begin : ready_chain
    logic chain;
    chain = out_ready;
    rdy_w = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain    = !stg_q[k].valid || chain;
      rdy_w[k] = chain;
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k] = stg_q[k];
      x_d[k]   = x_q[k];
      y_d[k]   = y_q[k];
      msb_d[k] = msb_q[k];
      if (rdy_w[k]) begin
        stg_d[k].valid = up_valid_w[k];
      end
      if (rdy_w[k] && up_valid_w[k]) begin
        stg_d[k].carry             = co_w[k];
        x_d[k]                     = up_x_w[k];
        x_d[k][k*CHUNK +: CHUNK]   = s_w[k];
        y_d[k]                     = up_y_w[k];
        msb_d[k]                   = up_msb_w[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
        msb_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= stg_d[k];
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
        msb_q[k] <= msb_d[k];
      end
    end
  end

  assign in_ready  = rdy_w[0];
  assign out_valid = stg_q[STAGES-1].valid;
  assign sum       = x_q[STAGES-1];
  assign cout      = stg_q[STAGES-1].carry;
  assign ovf       = (msb_q[STAGES-1][1] == msb_q[STAGES-1][0]) &&
                     (x_q[STAGES-1][WIDTH-1] != msb_q[STAGES-1][1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - randomized self-checking bench for pipelined_adder
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        sw_in_valid [4];
  logic        sw_out_ready[4];
  logic        sw_cin      [4];
  logic [31:0] sw_a        [4];
  logic [31:0] sw_b        [4];
  logic        sw_in_ready [4];
  logic        sw_out_valid[4];
  logic        sw_cout     [4];
  logic        sw_ovf      [4];
  logic [31:0] sw_sum      [4];
  logic [15:0] sum0, sum1;
  logic [31:0] sum2;
  logic [7:0]  sum3;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];

  always #10 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_sw0 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
    .a(sw_a[0][15:0]), .b(sw_b[0][15:0]), .cin(sw_cin[0]), .out_valid(sw_out_valid[0]),
    .out_ready(sw_out_ready[0]), .sum(sum0), .cout(sw_cout[0]), .ovf(sw_ovf[0]));
  pipelined_adder #(.WIDTH(16), .STAGES(16)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
    .a(sw_a[1][15:0]), .b(sw_b[1][15:0]), .cin(sw_cin[1]), .out_valid(sw_out_valid[1]),
    .out_ready(sw_out_ready[1]), .sum(sum1), .cout(sw_cout[1]), .ovf(sw_ovf[1]));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_sw2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
    .a(sw_a[2]), .b(sw_b[2]), .cin(sw_cin[2]), .out_valid(sw_out_valid[2]),
    .out_ready(sw_out_ready[2]), .sum(sum2), .cout(sw_cout[2]), .ovf(sw_ovf[2]));
  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_sw3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[3]), .in_ready(sw_in_ready[3]),
    .a(sw_a[3][7:0]), .b(sw_b[3][7:0]), .cin(sw_cin[3]), .out_valid(sw_out_valid[3]),
    .out_ready(sw_out_ready[3]), .sum(sum3), .cout(sw_cout[3]), .ovf(sw_ovf[3]));

  assign sw_sum[0] = {16'h0, sum0};
  assign sw_sum[1] = {16'h0, sum1};
  assign sw_sum[2] = sum2;
  assign sw_sum[3] = {24'h0, sum3};

  // Reference: integer arithmetic on unsigned and signed interpretations -> {ovf, cout, sum}
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned ux   = {32'h0, x} & mask;
    longint unsigned uy   = {32'h0, y} & mask;
    longint unsigned tot  = ux + uy + {63'h0, c};
    longint half = longint'(64'd1 << (w - 1));
    longint sx   = (ux >= 64'(half)) ? longint'(ux) - 2 * half : longint'(ux);
    longint sy   = (uy >= 64'(half)) ? longint'(uy) - 2 * half : longint'(uy);
    longint st   = sx + sy + longint'({63'h0, c});
    logic [33:0] r;
    r[31:0] = 32'(tot & mask);
    r[32]   = tot[w];
    r[33]   = (st > half - 1) || (st < -half);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      #1;
      total++;
      if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL reset: ov=%b sum=%h cout=%b ovf=%b ir=%b, want 0 0000 0 0 1",
                 out_valid, sum, cout, ovf, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL single_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      total++;
      if (out_valid !== (c == 4)) begin
        bad++; $display("FAIL single_latency: cycle %0d out_valid=%b want %b", c, out_valid, c == 4);
      end
      if (c == 4) begin
        total++;
        if ({sum, cout, ovf} !== {16'h0100, 1'b0, 1'b0}) begin
          bad++; $display("FAIL single_sum: got %h c=%b o=%b want 0100 0 0", sum, cout, ovf);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va[4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] vb[4] = '{16'h0001, 16'h0001, 16'h8000, 16'h0000};
    logic        vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] es[4] = '{16'h0000, 16'h8000, 16'h0000, 16'h0000};
    logic        ec[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        eo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int waited;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      waited = 1;
      while (out_valid !== 1'b1 && waited < 10) begin
        @(negedge clk); #1; waited++;
      end
      total++;
      if (out_valid !== 1'b1) begin
        bad++; $display("FAIL vector%0d_timeout: no out_valid within 10 cycles", i);
      end else if ({sum, cout, ovf} !== {es[i], ec[i], eo[i]}) begin
        bad++;
        $display("FAIL vector%0d: got %h c=%b o=%b want %h c=%b o=%b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          occ = 0, sent = 0, got = 0;
    logic        have = 1'b0, prev_stall = 1'b0, saw_block = 1'b0, exp_ready;
    logic [15:0] prev_sum = '0;
    logic [33:0] r;
    exp_q.delete();
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      if (sent < 8) begin
        if (!have) begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1)); have = 1'b1;
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = pat[cyc % 4];
      #1;
      exp_ready = (occ < 4) || out_ready;
      if (occ == 4 && !out_ready) saw_block = 1'b1;
      total++;
      if (in_ready !== exp_ready) begin
        bad++; $display("FAIL b2b_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_ready);
      end
      if (prev_stall) begin
        total++;
        if (sum !== prev_sum || out_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_stall_hold: sum %h ov=%b want %h ov=1", sum, out_valid, prev_sum);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: got %h with nothing expected", sum);
        end else begin
          r = exp_q.pop_front();
          if ({ovf, cout, sum} !== {r[33], r[32], r[15:0]}) begin
            bad++; $display("FAIL b2b_result%0d: got %h c=%b o=%b want %h c=%b o=%b",
                            got, sum, cout, ovf, r[15:0], r[32], r[33]);
          end
        end
        got++; occ--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(16, {16'h0, a}, {16'h0, b}, cin));
        sent++; occ++; have = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
    end
    total++;
    if (got != 8 || exp_q.size() != 0 || !saw_block) begin
      bad++; $display("FAIL b2b_count: got %0d left %0d full_stall_seen=%b want 8 0 1",
                      got, exp_q.size(), saw_block);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int          waited;
    logic [33:0] r;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      #1;
      if (in_ready) exp_q.push_back(ref_add(16, {16'h0, a}, {16'h0, b}, cin));
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    total++;
    if (out_valid !== 1'b1 || exp_q.size() != 3) begin
      bad++; $display("FAIL midrst_setup: ov=%b queued=%0d want 1 3", out_valid, exp_q.size());
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h0}) begin
      bad++; $display("FAIL midrst_async: ov=%b ir=%b sum=%h want 0 1 0000", out_valid, in_ready, sum);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL midrst_stale: cycle %0d out_valid=%b want 0", c, out_valid);
      end
    end
    @(negedge clk);
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
    r = ref_add(16, {16'h0, a}, {16'h0, b}, cin);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      total++;
      if (out_valid !== (c == 4)) begin
        bad++; $display("FAIL midrst_latency: cycle %0d out_valid=%b want %b", c, out_valid, c == 4);
      end
      if (c == 4) begin
        total++;
        if ({ovf, cout, sum} !== {r[33], r[32], r[15:0]}) begin
          bad++; $display("FAIL midrst_result: got %h c=%b o=%b want %h c=%b o=%b",
                          sum, cout, ovf, r[15:0], r[32], r[33]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_param_sweep();
    int          w[4] = '{16, 16, 32, 8};
    logic [33:0] sq[4][$];
    logic [33:0] r;
    for (int cyc = 0; cyc < 14000 + 60; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (cyc < 14000) begin
          sw_in_valid[i]  = ($urandom_range(0, 3) != 0);
          sw_out_ready[i] = ($urandom_range(0, 3) != 0);
        end else begin
          sw_in_valid[i]  = 1'b0;
          sw_out_ready[i] = 1'b1;
        end
        sw_a[i] = $urandom; sw_b[i] = $urandom; sw_cin[i] = 1'($urandom_range(0, 1));
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (sw_out_valid[i] && sw_out_ready[i]) begin
          total++;
          if (sq[i].size() == 0) begin
            bad++; $display("FAIL sweep%0d_extra: got %h with nothing expected", i, sw_sum[i]);
          end else begin
            r = sq[i].pop_front();
            if ({sw_ovf[i], sw_cout[i], sw_sum[i]} !== r) begin
              bad++; $display("FAIL sweep%0d: got %h c=%b o=%b want %h c=%b o=%b", i,
                              sw_sum[i], sw_cout[i], sw_ovf[i], r[31:0], r[32], r[33]);
            end
          end
        end
        if (sw_in_valid[i] && sw_in_ready[i])
          sq[i].push_back(ref_add(w[i], sw_a[i], sw_b[i], sw_cin[i]));
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sq[i].size() != 0) begin
        bad++; $display("FAIL sweep%0d_drain: %0d results never emerged", i, sq[i].size());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw_in_valid[i] = 1'b0; sw_out_ready[i] = 1'b0; sw_cin[i] = 1'b0; sw_a[i] = '0; sw_b[i] = '0;
    end
    test_reset();
    test_single();
    test_vectors();
    test_back_to_back();
    test_reset_midstream();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
